// File: rtl/topk_argmax_stream.sv
// Streaming top-K score selector: keeps the K best signed scores (max or min mode)
// with their arrival indices and presents the ranked table over a valid/ready handshake.
module topk_argmax_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 10,
    parameter int K          = 3,
    parameter int IDXW       = (DIM <= 1) ? 1 : $clog2(DIM)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode_min,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [K*IDXW-1:0]            out_idx,
    output logic [K*DATA_WIDTH-1:0]      out_val,
    output logic [$clog2(K+1)-1:0]       out_cnt,
    output logic                         busy
);

    localparam int CNTW = IDXW + 1;
    localparam int CW   = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;

    state_t                        state, state_nx;
    logic                          mode_q;
    logic [CNTW-1:0]               cnt;
    logic [K-1:0]                  slot_vld;
    logic [IDXW-1:0]               slot_idx [K];
    logic signed [DATA_WIDTH-1:0]  slot_val [K];
    logic [K-1:0]                  better;
    logic [IDXW-1:0]               ins_idx  [K];
    logic signed [DATA_WIDTH-1:0]  ins_val  [K];
    logic                          accept, last_accept, clear_tbl;

    // abort outranks a same-cycle accept, so a dropped frame never touches the table.
    assign accept      = (state == LOAD) && in_valid && !abort;
    assign last_accept = accept && (cnt == CNTW'(DIM - 1));
    assign clear_tbl   = ((state == IDLE) && start) || ((state != IDLE) && abort);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments for every register so all flops update from the same pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise untaken branches infer latches.
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (abort)            state_nx = IDLE;
                else if (last_accept) state_nx = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (abort || out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The table stays sorted with empties at the tail, so 'better' is monotone:
    // the first set bit is the insertion point and every later set slot shifts down.
    always_comb begin
        better = '0;
        for (int i = 0; i < K; i++) begin
            better[i] = !slot_vld[i] ||
                        (mode_q ? (slot_val[i] > in_data) : (slot_val[i] < in_data));
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_slot
        if (g == 0) begin : g_head
            assign ins_idx[g] = cnt[IDXW-1:0];
            assign ins_val[g] = in_data;
        end else begin : g_tail
            assign ins_idx[g] = better[g-1] ? slot_idx[g-1] : cnt[IDXW-1:0];
            assign ins_val[g] = better[g-1] ? slot_val[g-1] : in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the table is a handful of flops and must read zero after reset, so it is reset like any other register.
        if (!reset) begin
            mode_q   <= 1'b0;
            cnt      <= '0;
            slot_vld <= '0;
            for (int i = 0; i < K; i++) begin
                slot_idx[i] <= '0;
                slot_val[i] <= '0;
            end
        end else if (clear_tbl) begin
            if (state == IDLE) mode_q <= mode_min;
            cnt      <= '0;
            slot_vld <= '0;
            for (int i = 0; i < K; i++) begin
                slot_idx[i] <= '0;
                slot_val[i] <= '0;
            end
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            for (int i = 0; i < K; i++) begin
                if (better[i]) begin
                    slot_vld[i] <= (i == 0) ? 1'b1 : (slot_vld[i-((i > 0) ? 1 : 0)] || !better[i-((i > 0) ? 1 : 0)]);
                    slot_idx[i] <= ins_idx[i];
                    slot_val[i] <= ins_val[i];
                end
            end
        end
    end

    always_comb begin
        out_idx = '0;
        out_val = '0;
        out_cnt = '0;
        for (int i = 0; i < K; i++) begin
            out_idx[i*IDXW +: IDXW]             = slot_idx[i];
            out_val[i*DATA_WIDTH +: DATA_WIDTH] = slot_val[i];
            out_cnt                             = out_cnt + CW'(slot_vld[i]);
        end
    end

endmodule

// File: tb/tb_topk_argmax_stream.sv
// Directed bench for topk_argmax_stream: three instances (DIM6/K3, DIM6/K8, DIM1/K1)
// driven from a vector table plus hand-written hold, abort and reset sequences.
module tb_topk_argmax_stream;

    localparam int DW = 16;
    localparam int NV = 6;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_c, mode_min, abort, in_valid, out_ready;
    logic signed [DW-1:0] in_data;

    logic        a_in_ready, a_out_valid, a_busy;
    logic [8:0]  a_out_idx;
    logic [47:0] a_out_val;
    logic [1:0]  a_out_cnt;

    logic         b_in_ready, b_out_valid, b_busy;
    logic [23:0]  b_out_idx;
    logic [127:0] b_out_val;
    logic [3:0]   b_out_cnt;

    logic          c_in_ready, c_out_valid, c_busy;
    logic [0:0]    c_out_idx;
    logic [DW-1:0] c_out_val;
    logic [0:0]    c_out_cnt;

    topk_argmax_stream #(.DATA_WIDTH(DW), .DIM(6), .K(3)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode_min(mode_min), .abort(abort),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_idx(a_out_idx),
        .out_val(a_out_val), .out_cnt(a_out_cnt), .busy(a_busy));

    topk_argmax_stream #(.DATA_WIDTH(DW), .DIM(6), .K(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_a), .mode_min(mode_min), .abort(abort),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_idx(b_out_idx),
        .out_val(b_out_val), .out_cnt(b_out_cnt), .busy(b_busy));

    topk_argmax_stream #(.DATA_WIDTH(DW), .DIM(1), .K(1)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .mode_min(mode_min), .abort(abort),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_idx(c_out_idx),
        .out_val(c_out_val), .out_cnt(c_out_cnt), .busy(c_busy));

    always #5 clk = ~clk;

    typedef struct packed {
        logic                mode;
        logic                gap;
        logic [5:0][DW-1:0]  sc;
        logic [2:0][2:0]     ei;
        logic [2:0][DW-1:0]  ev;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   mode_tab [NV]    = '{0, 1, 1, 0, 0, 1};
    int   gap_tab  [NV]    = '{0, 0, 1, 0, 0, 0};
    int   sc_tab   [NV][6] = '{'{-3, -1, -7, -1, -2, -9},
                               '{ 1,  2,  3,  9,  8,  0},
                               '{ 1,  2,  3,  9,  8,  0},
                               '{ 0,  5,  2,  5,  1,  4},
                               '{ 1,  2,  3,  9,  8,  0},
                               '{-32768, 32767, 0, -32768, 5, -1}};
    int   ei_tab   [NV][3] = '{'{1, 3, 4}, '{5, 0, 1}, '{5, 0, 1},
                               '{1, 3, 5}, '{3, 4, 2}, '{0, 3, 5}};
    int   ev_tab   [NV][3] = '{'{-1, -1, -2}, '{0, 1, 2}, '{0, 1, 2},
                               '{5, 5, 4}, '{9, 8, 3}, '{-32768, -32768, -1}};
    int   b_ei     [8]     = '{1, 3, 5, 2, 4, 0, 0, 0};
    int   b_ev     [8]     = '{5, 5, 4, 2, 1, 0, 0, 0};

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Starts a frame on A/B and streams six scores; mode_min is flipped after start
    // to show the mode is latched. Returns at the negedge where out_valid must be up.
    task automatic feed(input logic mode, input logic gap, input logic [5:0][DW-1:0] sc);
        start_a  = 1'b1;
        mode_min = mode;
        @(negedge clk);
        start_a  = 1'b0;
        mode_min = ~mode;
        for (int i = 0; i < 6; i++) begin
            check("in_ready_load", longint'(a_in_ready), 1);
            in_valid = 1'b1;
            in_data  = sc[i];
            @(negedge clk);
            if (gap) begin
                in_valid = 1'b0;
                in_data  = 16'sd7777;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        check("out_valid_after_last", longint'(a_out_valid), 1);
        check("in_ready_out", longint'(a_in_ready), 0);
    endtask

    task automatic check_a(input vec_t v);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("a_idx%0d", s), longint'(a_out_idx[s*3 +: 3]), longint'(v.ei[s]));
            check($sformatf("a_val%0d", s), longint'($signed(a_out_val[s*DW +: DW])),
                  longint'($signed(v.ev[s])));
        end
        check("a_cnt", longint'(a_out_cnt), 3);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_idx"}, longint'(a_out_idx), 0);
        check({tag, "_val"}, longint'(a_out_val), 0);
        check({tag, "_cnt"}, longint'(a_out_cnt), 0);
        check({tag, "_busy"}, longint'(a_busy), 0);
        check({tag, "_in_ready"}, longint'(a_in_ready), 0);
        check({tag, "_out_valid"}, longint'(a_out_valid), 0);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_ready_busy", longint'(a_busy), 0);
        check("idle_after_ready_valid", longint'(a_out_valid), 0);
    endtask

    initial begin
        for (int v = 0; v < NV; v++) begin
            vecs[v].mode = 1'(mode_tab[v]);
            vecs[v].gap  = 1'(gap_tab[v]);
            for (int i = 0; i < 6; i++) vecs[v].sc[i] = DW'(sc_tab[v][i]);
            for (int i = 0; i < 3; i++) begin
                vecs[v].ei[i] = 3'(ei_tab[v][i]);
                vecs[v].ev[i] = DW'(ev_tab[v][i]);
            end
        end

        reset = 1'b0; start_a = 1'b0; start_c = 1'b0; mode_min = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_a_zero("reset");
        check("reset_c_valid", longint'(c_out_valid), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            feed(vecs[v].mode, vecs[v].gap, vecs[v].sc);
            check_a(vecs[v]);
            if (v == 3) begin
                for (int s = 0; s < 8; s++) begin
                    check($sformatf("b_idx%0d", s), longint'(b_out_idx[s*3 +: 3]), longint'(b_ei[s]));
                    check($sformatf("b_val%0d", s), longint'($signed(b_out_val[s*DW +: DW])),
                          longint'(b_ev[s]));
                end
                check("b_cnt", longint'(b_out_cnt), 6);
                check("b_valid", longint'(b_out_valid), 1);
            end
            release_result();
        end

        // Result held under back-pressure; a start pulse during the hold is ignored.
        feed(vecs[0].mode, vecs[0].gap, vecs[0].sc);
        for (int h = 0; h < 10; h++) begin
            start_a = (h == 4);
            check("hold_valid", longint'(a_out_valid), 1);
            check("hold_in_ready", longint'(a_in_ready), 0);
            check_a(vecs[0]);
            @(negedge clk);
        end
        start_a   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start_a   = 1'b0;
        out_ready = 1'b0;
        check("start_with_ready_idle", longint'(a_busy), 0);
        @(negedge clk);
        check("no_restart_busy", longint'(a_busy), 0);
        check_a(vecs[0]);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_busy", longint'(a_busy), 0);
        check_a(vecs[0]);

        // Abort after three accepts, with a competing beat in the abort cycle.
        start_a  = 1'b1;
        mode_min = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(30000 + i);
            @(negedge clk);
        end
        abort   = 1'b1;
        in_data = 16'sd31000;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check_a_zero("abort");
        feed(vecs[4].mode, vecs[4].gap, vecs[4].sc);
        check_a(vecs[4]);
        release_result();

        // Asynchronous reset mid-frame.
        start_a  = 1'b1;
        mode_min = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(100 + i);
            @(negedge clk);
        end
        check("pre_reset_busy", longint'(a_busy), 1);
        reset = 1'b0;
        #1;
        check_a_zero("mid_reset");
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);

        // DIM=1, K=1 instance with the most negative score.
        start_c  = 1'b1;
        mode_min = 1'b0;
        @(negedge clk);
        start_c = 1'b0;
        check("c_in_ready", longint'(c_in_ready), 1);
        in_valid = 1'b1;
        in_data  = 16'sh8000;
        @(negedge clk);
        in_valid = 1'b0;
        check("c_valid", longint'(c_out_valid), 1);
        check("c_idx", longint'(c_out_idx), 0);
        check("c_val", longint'($signed(c_out_val)), -32768);
        check("c_cnt", longint'(c_out_cnt), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("c_idle", longint'(c_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
